// File: rtl/drum_sample_player_pkg.sv
// drum_sample_player_pkg: shared audio voice types and constants
package drum_sample_player_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, EMIT} state_t;
  localparam int READ_LATENCY = 1;
  localparam int GAIN_SHIFT = 3;
endpackage

// File: rtl/drum_sample_player_gain.sv
// drum_gain: combinational signed sample times (velocity+1)/8, floor rounding
module drum_gain
  import drum_sample_player_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] sample,
  input  logic [2:0]       velocity,
  output logic [WIDTH-1:0] scaled
);
  logic [3:0] gain;
  logic signed [WIDTH+3:0] prod;
  assign gain = {1'b0, velocity} + 4'd1;
  assign prod = $signed({{4{sample[WIDTH-1]}}, sample}) * $signed({{WIDTH{1'b0}}, gain});
  assign scaled = WIDTH'(prod >>> GAIN_SHIFT);
endmodule

// File: rtl/drum_sample_player.sv
// drum_sample_player: walks a BRAM address range per audio strobe and emits velocity-scaled samples
module drum_sample_player
  import drum_sample_player_pkg::*;
#(
  parameter int LOGSIZE = 14,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  input  logic               trigger,
  input  logic [2:0]         velocity,
  input  logic [LOGSIZE-1:0] start_addr,
  input  logic [LOGSIZE-1:0] end_addr,
  output logic [LOGSIZE-1:0] mem_addr,
  input  logic [WIDTH-1:0]   mem_dout,
  output logic [WIDTH-1:0]   sample_out,
  output logic               sample_valid,
  output logic               busy
);
  state_t state;
  logic [LOGSIZE-1:0] ptr, end_r;
  logic [2:0] vel_r;
  logic playing;
  logic [WIDTH-1:0] scaled;
  drum_gain #(.WIDTH(WIDTH)) u_gain (.sample(mem_dout), .velocity(vel_r), .scaled(scaled));
  // State names the cycle's visible outputs: ISSUE has mem_addr, WAIT has mem_dout, EMIT has sample_valid
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      end_r <= '0;
      vel_r <= '0;
      playing <= 1'b0;
      busy <= 1'b0;
      mem_addr <= '0;
      sample_out <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (trigger) begin
        vel_r <= velocity;
        end_r <= end_addr;
        ptr <= start_addr;
        playing <= 1'b1;
        busy <= 1'b1;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (ready) begin
            mem_addr <= ptr;
            state <= ISSUE;
          end
          ISSUE: state <= WAIT;
          WAIT: begin
            sample_out <= playing ? scaled : '0;
            sample_valid <= 1'b1;
            if (playing && ptr == end_r) begin
              playing <= 1'b0;
              busy <= 1'b0;
            end else if (playing) ptr <= ptr + LOGSIZE'(1);
            state <= EMIT;
          end
          EMIT: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_drum_sample_player.sv
// tb_drum_sample_player: directed checks of drum_sample_player against a registered-read RAM model
module tb_drum_sample_player;
  logic clk = 0, reset = 1, ready = 0, trigger = 0;
  logic [2:0] velocity = 0;
  logic [13:0] start_addr = 0, end_addr = 0, mem_addr;
  logic [7:0] mem_dout, sample_out;
  logic sample_valid, busy;
  logic [7:0] ram [0:16383];
  int tests = 0, failed = 0;

  drum_sample_player #(.LOGSIZE(14), .WIDTH(8)) dut (
    .clk(clk), .reset(reset), .ready(ready), .trigger(trigger), .velocity(velocity),
    .start_addr(start_addr), .end_addr(end_addr), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) mem_dout <= ram[mem_addr];

  task automatic do_ready(output logic [7:0] out, output logic [13:0] addr, output int lat,
                          output logic bsy, output logic extra);
    @(negedge clk) ready = 1;
    @(negedge clk) ready = 0;
    addr = mem_addr;
    lat = 0; out = 0; bsy = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (i > 1) @(negedge clk);
      if (sample_valid) begin lat = i; out = sample_out; bsy = busy; end
    end
    @(negedge clk) extra = sample_valid;
  endtask

  task automatic do_trigger(input logic [13:0] s, input logic [13:0] e, input logic [2:0] v);
    @(negedge clk) begin trigger = 1; start_addr = s; end_addr = e; velocity = v; end
    @(negedge clk) trigger = 0;
  endtask

  task automatic count_valid(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin @(negedge clk); if (sample_valid) c++; end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({mem_addr, sample_out, sample_valid, busy} !== 24'd0) begin
      failed++; $display("FAIL reset: addr=%0d out=%h valid=%b busy=%b required all 0", mem_addr, sample_out, sample_valid, busy);
    end
    reset = 0;
  endtask

  task automatic test_idle;
    logic [7:0] o; logic [13:0] a; int l; logic b, x;
    for (int k = 0; k < 3; k++) begin
      do_ready(o, a, l, b, x);
      tests++;
      if (l !== 3 || o !== 8'h00 || b !== 1'b0 || x !== 1'b0) begin
        failed++; $display("FAIL idle[%0d]: lat=%0d out=%h busy=%b after=%b required lat=3 out=00 busy=0 after=0", k, l, o, b, x);
      end
    end
  endtask

  task automatic test_ramp;
    logic [7:0] o; logic [13:0] a; int l; logic b, x;
    logic [7:0] eo [5] = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd0};
    logic eb [5] = '{1, 1, 1, 0, 0};
    do_trigger(10, 13, 7);
    tests++;
    if (busy !== 1'b1) begin failed++; $display("FAIL ramp_busy_rise: busy=%b required 1", busy); end
    for (int k = 0; k < 5; k++) begin
      do_ready(o, a, l, b, x);
      tests++;
      if (l !== 3 || o !== eo[k] || b !== eb[k] || (k < 4 && a !== 14'(10 + k))) begin
        failed++; $display("FAIL ramp[%0d]: lat=%0d out=%0d busy=%b addr=%0d required lat=3 out=%0d busy=%b addr=%0d", k, l, o, b, a, eo[k], eb[k], 10 + k);
      end
    end
  endtask

  task automatic test_single;
    logic [7:0] o; logic [13:0] a; int l; logic b, x;
    ram[5] = 8'h9C;
    do_trigger(5, 5, 3);
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'hCE || b !== 1'b0 || a !== 14'd5) begin
      failed++; $display("FAIL single_vel3: out=%h busy=%b addr=%0d required out=ce busy=0 addr=5", o, b, a);
    end
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'h00 || l !== 3) begin failed++; $display("FAIL single_after: out=%h lat=%0d required out=00 lat=3", o, l); end
    do_trigger(5, 5, 0);
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'hF3 || b !== 1'b0) begin failed++; $display("FAIL single_vel0: out=%h busy=%b required out=f3 busy=0", o, b); end
  endtask

  task automatic test_wrap;
    logic [7:0] o; logic [13:0] a; int l; logic b, x;
    logic [13:0] ea [4] = '{14'd16382, 14'd16383, 14'd0, 14'd1};
    logic [7:0] eo [4] = '{8'h21, 8'h22, 8'h23, 8'h24};
    logic eb [4] = '{1, 1, 1, 0};
    ram[16382] = 8'h21; ram[16383] = 8'h22; ram[0] = 8'h23; ram[1] = 8'h24;
    do_trigger(16382, 1, 7);
    for (int k = 0; k < 4; k++) begin
      do_ready(o, a, l, b, x);
      tests++;
      if (a !== ea[k] || o !== eo[k] || b !== eb[k]) begin
        failed++; $display("FAIL wrap[%0d]: addr=%0d out=%h busy=%b required addr=%0d out=%h busy=%b", k, a, o, b, ea[k], eo[k], eb[k]);
      end
    end
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'h00 || b !== 1'b0) begin failed++; $display("FAIL wrap_idle: out=%h busy=%b required out=00 busy=0", o, b); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] o; logic [13:0] a; int l; logic b, x; int c;
    for (int i = 0; i < 128; i++) ram[i] = 8'(i);
    do_trigger(20, 29, 7);
    for (int k = 0; k < 2; k++) begin
      do_ready(o, a, l, b, x);
      tests++;
      if (o !== 8'(20 + k)) begin failed++; $display("FAIL retrig_word[%0d]: out=%0d required %0d", k, o, 20 + k); end
    end
    @(negedge clk) ready = 1;
    @(negedge clk) begin ready = 0; trigger = 1; start_addr = 40; end_addr = 45; velocity = 1; end
    @(negedge clk) trigger = 0;
    count_valid(5, c);
    tests++;
    if (c !== 0) begin failed++; $display("FAIL retrig_drop: valid pulses=%0d required 0", c); end
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'd10 || a !== 14'd40 || b !== 1'b1) begin
      failed++; $display("FAIL retrig_new: out=%0d addr=%0d busy=%b required out=10 addr=40 busy=1", o, a, b);
    end
    @(negedge clk) begin ready = 1; trigger = 1; start_addr = 60; end_addr = 60; velocity = 3; end
    @(negedge clk) begin ready = 0; trigger = 0; end
    count_valid(5, c);
    tests++;
    if (c !== 0) begin failed++; $display("FAIL coincide_ignored: valid pulses=%0d required 0", c); end
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'd30 || a !== 14'd60 || b !== 1'b0 || l !== 3) begin
      failed++; $display("FAIL coincide_new: out=%0d addr=%0d busy=%b lat=%0d required out=30 addr=60 busy=0 lat=3", o, a, b, l);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] o; logic [13:0] a; int l; logic b, x; int c;
    do_trigger(10, 13, 7);
    @(negedge clk) ready = 1;
    @(negedge clk) ready = 0;
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
    tests++;
    if ({mem_addr, sample_out, sample_valid, busy} !== 24'd0) begin
      failed++; $display("FAIL reset_mid: addr=%0d out=%h valid=%b busy=%b required all 0", mem_addr, sample_out, sample_valid, busy);
    end
    count_valid(5, c);
    tests++;
    if (c !== 0) begin failed++; $display("FAIL reset_mid_quiet: valid pulses=%0d required 0", c); end
    do_ready(o, a, l, b, x);
    tests++;
    if (o !== 8'h00 || b !== 1'b0 || l !== 3) begin
      failed++; $display("FAIL reset_mid_after: out=%h busy=%b lat=%0d required out=00 busy=0 lat=3", o, b, l);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = (i < 128) ? 8'(i) : 8'h00;
    test_reset;
    test_idle;
    test_ramp;
    test_single;
    test_wrap;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/drum_sample_player.md
# drum_sample_player

Reads a stored drum sample out of a single-port block RAM, one word per audio sample strobe, and emits it scaled by a trigger velocity. Sits between the sample BRAM's read port and the audio mixer: a hit detector pulses `trigger`, the player walks the address range `start_addr`..`end_addr`, and the mixer consumes `sample_out` on `sample_valid`. The player never writes the RAM; loading is done elsewhere.

## Interface
- `LOGSIZE`, 14, BRAM address width (depth 2^LOGSIZE)
- `WIDTH`, 8, sample width, two's-complement signed
- `clk` input 1 system clock; all logic on rising edge
- `reset` input 1 synchronous, active-high; one clock, synchronous active-high reset
- `ready` input 1 one-cycle audio sample strobe (≥4 cycles apart)
- `trigger` input 1 one-cycle hit pulse; starts/restarts playback
- `velocity` input 3 gain code latched on `trigger`; gain = (velocity+1)/8
- `start_addr` input LOGSIZE first sample address, latched on `trigger`
- `end_addr` input LOGSIZE last sample address (inclusive), latched on `trigger`
- `mem_addr` output LOGSIZE registered address to BRAM read port (BRAM write-enable tied 0 at top level)
- `mem_dout` input WIDTH BRAM registered read data, valid one edge after `mem_addr`
- `sample_out` output WIDTH scaled signed sample
- `sample_valid` output 1 one-cycle pulse, `sample_out` new this cycle
- `busy` output 1 high while a sample is playing

## Operation
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE: `busy`=0. On `ready`: go ISSUE with playing flag clear (silence fetch).
- PLAY is a flag, not a state: set on `trigger`, cleared after the `end_addr` word is emitted.
- `trigger` (any state): latch `velocity`, `start_addr`, `end_addr`; ptr <= `start_addr`; playing <= 1; `busy` <= 1; any fetch in flight is abandoned (no `sample_valid` from it); return to IDLE-of-pipeline (wait for next `ready`).
- `trigger` and `ready` same cycle: trigger wins, `ready` ignored; first word fetched on next `ready`.
- ISSUE (entered on `ready` edge): `mem_addr` <= ptr. → WAIT.
- WAIT: BRAM registers `mem_dout`. → EMIT.
- EMIT: `sample_out` <= playing ? scale(`mem_dout`) : 0; `sample_valid` <= 1. If playing and ptr == end_addr: playing <= 0, `busy` <= 0. Else if playing: ptr <= ptr+1 mod 2^LOGSIZE. → IDLE.
- Scale: signed(`mem_dout`) × unsigned(velocity+1) in WIDTH+4 bits, arithmetic shift right 3, keep low WIDTH bits; never overflows since gain ≤ 1. Rounds toward −∞.
- Wrap: `end_addr` < `start_addr` plays start..2^LOGSIZE−1, 0..end. `start_addr` == `end_addr` plays exactly one word.
- `ready` arriving outside IDLE is ignored (cannot happen at spec’d strobe spacing).

## Timing
- Reset values: `mem_addr`=0, `sample_out`=0, `sample_valid`=0, `busy`=0, ptr=0, playing=0, state IDLE, latched regs 0.
- `reset` mid-playback aborts immediately; no further `sample_valid` until a `ready` after reset deasserts.
- Latency: `ready` sampled at edge E0 → `mem_addr` valid after E0 → `mem_dout` after E1 → `sample_out`/`sample_valid` after E2 (3rd cycle after `ready` cycle).
- `sample_valid` pulses exactly once per accepted `ready`, playing or idle (continuous stream to mixer; zero while idle).
- `busy` rises the edge after `trigger`; falls the same edge the last word’s `sample_valid` rises.

## Structure
- Shared audio package: state enum, `READ_LATENCY`=1, gain shift constant 3.
- Sub-module `drum_gain`: registered-output-free signed×unsigned scale and shift, parameterised on WIDTH; reused by other voices.
- Bench instantiates a real `mybram`-style RAM model preloaded with a ramp.

## Test plan
- Reset then three `ready` strobes, no trigger → three `sample_valid` pulses, `sample_out`=0, `busy`=0, 3-cycle latency each.
- RAM[i]=i (i<128); trigger start=10,end=13,vel=7 → outputs 10,11,12,13, then zeros; `busy` falls with 13.
- RAM[5]=−100 (8'h9C), start=end=5, vel=3 → single output −50 (8'hCE); vel=0 with −100 → −13.
- Wrap, LOGSIZE=14: start=16382,end=1 → addresses 16382,16383,0,1 in order, then idle.
- Retrigger on word 2 of a 10-word sample, also coinciding with `ready` → in-flight fetch dropped, next output is new `start_addr` with new velocity.
- Assert `reset` during WAIT → no `sample_valid` that fetch, all outputs 0, `busy`=0 next cycle.
